// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for a single-port data memory with
// burst-limited ownership and registered per-master load responses.
module dmem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state;
    logic [3:0] burst_cnt;
    logic       last_owner;
    logic       limit;
    logic       g0;
    logic       g1;
    logic       same;

    assign limit = burst_cnt >= 4'(MAX_BURST);

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        case (state)
            OWN0: begin
                g0 = m0_req && (!m1_req || !limit);
                g1 = !g0 && m1_req;
            end
            OWN1: begin
                g1 = m1_req && (!m0_req || !limit);
                g0 = !g1 && m0_req;
            end
            default: begin
                g0 = m0_req && (!m1_req || last_owner);
                g1 = m1_req && (!m0_req || !last_owner);
            end
        endcase
    end

    // Grants are suppressed combinationally while reset is held.
    assign m0_gnt    = g0 & rst_n;
    assign m1_gnt    = g1 & rst_n;
    assign mem_addr  = m0_gnt ? m0_addr : m1_gnt ? m1_addr : 32'd0;
    assign mem_wdata = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : 32'd0;
    assign mem_rw    = (m0_gnt & m0_we) | (m1_gnt & m1_we);
    assign same      = (m0_gnt && state == OWN0) || (m1_gnt && state == OWN1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            burst_cnt  <= 4'd0;
            last_owner <= 1'b1;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_rdata   <= 32'd0;
            m1_rdata   <= 32'd0;
        end else begin
            if (m0_gnt || m1_gnt) begin
                state      <= m0_gnt ? OWN0 : OWN1;
                last_owner <= m1_gnt;
                burst_cnt  <= !same ? 4'd1 : (burst_cnt == 4'd15) ? 4'd15 : burst_cnt + 4'd1;
            end else begin
                state     <= IDLE;
                burst_cnt <= 4'd0;
            end
            m0_rvalid <= m0_gnt & ~m0_we;
            m1_rvalid <= m1_gnt & ~m1_we;
            if (m0_gnt && !m0_we)
                m0_rdata <= mem_rdata;
            if (m1_gnt && !m1_we)
                m1_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench running MAX_BURST=4 and MAX_BURST=1 arbiters
// side by side on shared randomized stimulus against a transaction-level model.
module tb_dmem_arbiter;
    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    int          vectors;
    int          miscompares;
    int          cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int inst, input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d cyc %0d: got %h expected %h", name, inst, cyc, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int MB = (k == 0) ? 4 : 1;
        logic [1:0]  gnt;
        logic [1:0]  rvalid;
        logic [31:0] rdata [2];
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] mem_rdata;
        logic        mem_rw;
        logic [31:0] mem     [256];
        logic [31:0] ref_mem [256];
        logic [31:0] last_rd [2];
        rsp_t        q [2][$];
        int          owner;
        int          run;
        int          last;
        int          win;
        logic [1:0]  exp_g;
        logic        exp_v;

        initial begin
            owner = -1;
            run   = 0;
            last  = 1;
            for (int i = 0; i < 256; i++) begin
                mem[i]     = (i * 32'h01010101) ^ 32'hA5A50000;
                ref_mem[i] = (i * 32'h01010101) ^ 32'hA5A50000;
            end
        end

        assign mem_rdata = mem[mem_addr[9:2]];
        always @(posedge clk) if (mem_rw) mem[mem_addr[9:2]] <= mem_wdata;

        dmem_arbiter #(.MAX_BURST(MB)) dut (
            .clk(clk), .rst_n(rst_n),
            .m0_req(req[0]), .m1_req(req[1]), .m0_we(we[0]), .m1_we(we[1]),
            .m0_addr(addr[0]), .m1_addr(addr[1]), .m0_wdata(wdata[0]), .m1_wdata(wdata[1]),
            .m0_gnt(gnt[0]), .m1_gnt(gnt[1]), .m0_rvalid(rvalid[0]), .m1_rvalid(rvalid[1]),
            .m0_rdata(rdata[0]), .m1_rdata(rdata[1]),
            .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
        );

        // Reference model: who wins this cycle, what the bus must show, and which load responses to expect.
        always @(negedge clk) begin
            if (!rst_n) begin
                owner = -1;
                run   = 0;
                last  = 1;
                chk(k, "gnt_in_reset", {30'd0, gnt}, 32'd0);
                chk(k, "rw_in_reset", {31'd0, mem_rw}, 32'd0);
            end else begin
                if (owner >= 0 && req[owner] && (!req[1 - owner] || run < MB))
                    win = owner;
                else if (owner >= 0)
                    win = req[1 - owner] ? 1 - owner : -1;
                else if (req == 2'b11)
                    win = 1 - last;
                else
                    win = req[0] ? 0 : req[1] ? 1 : -1;
                exp_g = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
                chk(k, "gnt", {30'd0, gnt}, {30'd0, exp_g});
                chk(k, "mem_addr", mem_addr, (win < 0) ? 32'd0 : addr[win]);
                chk(k, "mem_wdata", mem_wdata, (win < 0) ? 32'd0 : wdata[win]);
                chk(k, "mem_rw", {31'd0, mem_rw}, {31'd0, win >= 0 && we[win]});
                if (win >= 0) begin
                    if (we[win])
                        ref_mem[addr[win][9:2]] = wdata[win];
                    else
                        q[win].push_back('{cyc + 1, ref_mem[addr[win][9:2]]});
                    run   = (win == owner) ? run + 1 : 1;
                    owner = win;
                    last  = win;
                end else begin
                    owner = -1;
                    run   = 0;
                end
            end
        end

        // Monitor: pops a response whenever one is due and checks rvalid/rdata against it.
        always @(negedge clk) begin
            for (int m = 0; m < 2; m++) begin
                if (!rst_n) begin
                    q[m].delete();
                    last_rd[m] = 32'd0;
                    chk(k, "rvalid_in_reset", {31'd0, rvalid[m]}, 32'd0);
                end else begin
                    exp_v = q[m].size() > 0 && q[m][0].cyc == cyc;
                    chk(k, m ? "m1_rvalid" : "m0_rvalid", {31'd0, rvalid[m]}, {31'd0, exp_v});
                    if (exp_v) begin
                        last_rd[m] = q[m][0].data;
                        void'(q[m].pop_front());
                    end
                end
                chk(k, m ? "m1_rdata" : "m0_rdata", rdata[m], last_rd[m]);
            end
        end
    end

    task automatic drive(input int m, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        req[m]   = r;
        we[m]    = w;
        addr[m]  = a;
        wdata[m] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        drive(0, 1'b1, 1'b1, 32'h10, 32'h1);
        drive(1, 1'b1, 1'b1, 32'h14, 32'h2);
        repeat (3) step();
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h8, 32'h0);
        drive(1, 1'b1, 1'b0, 32'hC, 32'h0);
        repeat (12) step();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 1'b1, 32'h20 + 32'(i * 4), $urandom);
            drive(1, 1'b1, 1'b1, 32'h80 + 32'(i * 4), $urandom);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 1'b0, 32'h20 + 32'(i * 4), 32'h0);
            drive(1, 1'b1, 1'b0, 32'h80 + 32'(i * 4), 32'h0);
            step();
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
        step();
        drive(1, 1'b1, 1'b0, 32'h40, 32'h0);
        step();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) step();
        drive(0, 1'b1, 1'b0, 32'h4, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h40, 32'h0);
        repeat (3) step();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        drive(1, 1'b1, 1'b1, 32'h44, 32'h5);
        repeat (2) step();
        rst_n = 1'b1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        for (int i = 0; i < 3000; i++) begin
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 3) == 0)
                    req[m] = ~req[m];
                we[m]    = $urandom_range(0, 2) == 0;
                addr[m]  = 32'($urandom_range(0, 23)) << 2;
                wdata[m] = $urandom;
            end
            step();
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
